// File: rtl/msk_share_serializer.sv
// Streams one masked sharing out one share-slice per handshake, share 0 first.
// Shares are only ever moved as whole slices; sent positions are zero-filled.
module msk_share_serializer #(
   parameter int unsigned d     = 2,
   parameter int unsigned count = 1,
   localparam int unsigned IW   = (d > 1) ? $clog2(d) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [count*d-1:0]   in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [count-1:0]     out_share,
   output logic [IW-1:0]        out_idx,
   output logic                 out_last,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned W        = count * d;
   localparam logic [IW-1:0] LAST_IDX = IW'(d - 1);

   typedef enum logic {IDLE, SEND} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    share_buf, share_buf_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;

   // State, shift buffer and output flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         share_buf   <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         share_buf   <= share_buf_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // Next state; flags are precomputed so every output comes straight off a flop
   always_comb begin
      state_d     = state_q;
      share_buf_d = share_buf;
      idx_d       = idx_q;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               share_buf_d = in_data;
               idx_d       = '0;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  share_buf_d = '0;
                  idx_d       = '0;
                  state_d     = IDLE;
               end else begin
                  share_buf_d = share_buf >> count;
                  idx_d       = idx_q + IW'(1);
               end
            end
         end
         default: begin
            share_buf_d = '0;
            idx_d       = '0;
            state_d     = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == SEND);
      out_last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_share = share_buf[count-1:0];
   assign out_idx   = idx_q;

endmodule
